matrix_row_loader: RTL

Upstream stage of the transpose FIFO bank in the systolic-array datapath. Fetches a DEPTH×DEPTH matrix of BITS-wide elements from memory one row-word at a time over a read-with-waitrequest bus. Each fetched row goes to the FIFO bank as a parallel row write (WrEn/Arow/Ain). After all rows are loaded, the block drives the shift enable long enough to fully drain the bank into the downstream delay stage.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matrix_row_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Package     : matmul_pkg
// Description : Shared types and helpers for the systolic-array matrix path.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    PUMP  = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

  // Shift cycles needed to fully drain a depth x depth transpose bank.
  function automatic int pump_cycles(input int depth);
    return 2 * depth - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_row_loader
// Description : Fetches a DEPTH x DEPTH matrix one row-word at a time, writes
//               each row into the transpose FIFO bank, then pumps it out.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_loader
  import matmul_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BITS   = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_address,
  input  logic                     mem_waitrequest,
  input  logic [DEPTH*BITS-1:0]    mem_readdata,
  input  logic                     mem_readdatavalid,
  output logic                     WrEn,
  output logic [$clog2(DEPTH)-1:0] Arow,
  output logic [BITS-1:0]          Ain [DEPTH],
  output logic                     en
);

  localparam int                  c_ROW_W     = $clog2(DEPTH);
  localparam int                  c_PUMP_N    = pump_cycles(DEPTH);
  localparam int                  c_PUMP_W    = $clog2(c_PUMP_N);
  localparam logic [ADDR_W-1:0]   c_STRIDE    = ADDR_W'(DEPTH * BITS / 8);
  localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(DEPTH - 1);
  localparam logic [c_PUMP_W-1:0] c_PUMP_LAST = c_PUMP_W'(c_PUMP_N - 1);

  loader_state_t         r_state;
  loader_state_t         w_state_next;
  logic [c_ROW_W-1:0]    r_row;
  logic [c_ROW_W-1:0]    w_row_next;
  logic [c_PUMP_W-1:0]   r_pump;
  logic [c_PUMP_W-1:0]   w_pump_next;
  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W-1:0]     w_addr_next;
  logic [BITS-1:0]       w_row_elem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
    assign w_row_elem[gi] = mem_readdata[gi*BITS +: BITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_pump  <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_pump  <= w_pump_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_pump_next  = r_pump;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = READ;
          w_row_next   = '0;
        end
      end
      READ: begin
        if (!mem_waitrequest) w_state_next = WAIT;
      end
      WAIT: begin
        if (mem_readdatavalid) w_state_next = WRITE;
      end
      WRITE: begin
        if (r_row == c_LAST_ROW) begin
          w_state_next = PUMP;
          w_pump_next  = '0;
        end else begin
          w_state_next = READ;
          w_row_next   = r_row + c_ROW_W'(1);
        end
      end
      PUMP: begin
        if (r_pump == c_PUMP_LAST) w_state_next = DONE;
        else                       w_pump_next  = r_pump + c_PUMP_W'(1);
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The first row address comes straight from base_addr since r_base is
  // being captured on the same edge.
  always_comb begin
    w_addr_next = ((r_state == IDLE) ? base_addr : r_base)
                + ADDR_W'(w_row_next) * c_STRIDE;
  end

  // Outputs are registered images of the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      WrEn        <= 1'b0;
      Arow        <= '0;
      en          <= 1'b0;
      r_base      <= '0;
    end else begin
      busy     <= (w_state_next != IDLE);
      done     <= (w_state_next == DONE);
      mem_read <= (w_state_next == READ);
      WrEn     <= (w_state_next == WRITE);
      en       <= (w_state_next == PUMP);
      if (r_state == IDLE && start) r_base <= base_addr;
      if (w_state_next == READ && r_state != READ) mem_address <= w_addr_next;
      if (w_state_next == WRITE) Arow <= r_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) Ain[i] <= '0;
    end else if (r_state == WAIT && mem_readdatavalid) begin
      Ain <= w_row_elem;
    end
  end

endmodule
`default_nettype wire
